// File: rtl/pulse_train_scheduler_pkg.sv
// Shared types and default constants for the pulse-train scheduler.
package pulse_sched_pkg;

  localparam int DATA_W    = 16;
  localparam int DEF_CFG_W = 14;

  localparam logic signed [DATA_W-1:0] DEF_LEVEL_HI = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] DEF_LEVEL_LO = 16'sh0000;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'd0,
    MODE_FREE_RUN  = 2'd1,
    MODE_EXT_BURST = 2'd2,
    MODE_SW_BURST  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN_HI = 2'd1,
    ST_RUN_LO = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_train_scheduler_trig_sync.sv
// Two-flop synchronizer for the external trigger followed by a registered
// rising-edge detector; emits a one-cycle trig_pulse.
module trig_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic trig_pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;
  logic pulse_d;

  always_comb begin
    pulse_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= async_in;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= pulse_d;
    end
  end

  assign trig_pulse = pulse_q;

endmodule

// File: rtl/pulse_train_scheduler.sv
// Square-wave scheduler: shadowed period/high/count, free-running or triggered
// bursts, with busy/done/pulse-count/overrun status.
module pulse_train_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int                        CFG_W    = DEF_CFG_W,
  parameter logic signed [DATA_W-1:0]  LEVEL_HI = DEF_LEVEL_HI,
  parameter logic signed [DATA_W-1:0]  LEVEL_LO = DEF_LEVEL_LO
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     exttrig,
  input  logic                     sw_trig,
  input  logic [1:0]               cfg_mode,
  input  logic [CFG_W-1:0]         cfg_period,
  input  logic [CFG_W-1:0]         cfg_high,
  input  logic [CFG_W-1:0]         cfg_count,
  output logic signed [DATA_W-1:0] outputa,
  output logic                     busy,
  output logic                     done,
  output logic [CFG_W-1:0]         pulses_done,
  output logic                     trig_overrun
);

  // One extra bit: the longest period (2^CFG_W cycles) needs it.
  localparam int PW = CFG_W + 1;
  localparam logic [CFG_W-1:0] CNT_MAX = '1;

  function automatic logic [PW-1:0] clamp_period(input logic [CFG_W-1:0] per);
    logic [PW-1:0] p;
    p = (per == '0) ? PW'(1) : {1'b0, per};
    return p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] clamp_high(input logic [CFG_W-1:0] hi,
                                               input logic [PW-1:0]    p);
    return ({1'b0, hi} > p) ? p : {1'b0, hi};
  endfunction

  function automatic logic [CFG_W-1:0] sat_inc(input logic [CFG_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CFG_W'(1);
  endfunction

  state_e                   state_q, state_d;
  mode_e                    run_mode_q, run_mode_d;
  mode_e                    live_mode;
  logic [PW-1:0]            phase_q, phase_d;
  logic [PW-1:0]            p_q, p_d;
  logic [PW-1:0]            h_q, h_d;
  logic [CFG_W-1:0]         n_q, n_d;
  logic [CFG_W-1:0]         cnt_q, cnt_d;
  logic                     done_q, done_d;
  logic                     ovr_q, ovr_d;
  logic                     busy_q, busy_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic                     sw_trig_q;
  logic                     ext_pulse;
  logic                     trig;
  logic [PW-1:0]            live_p;
  logic [PW-1:0]            live_h;

  trig_sync u_trig_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (exttrig),
    .trig_pulse (ext_pulse)
  );

  always_comb begin
    live_mode = mode_e'(cfg_mode);
    live_p    = clamp_period(cfg_period);
    live_h    = clamp_high(cfg_high, live_p);
    trig      = ((live_mode == MODE_EXT_BURST) && ext_pulse) ||
                ((live_mode == MODE_SW_BURST)  && sw_trig_q);
  end

  always_comb begin
    state_d    = state_q;
    run_mode_d = run_mode_q;
    phase_d    = phase_q;
    p_d        = p_q;
    h_d        = h_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q;

    if (state_q == ST_IDLE) begin
      // The done cycle still refuses triggers; they count as overruns.
      if (!done_q && ((live_mode == MODE_FREE_RUN) || trig)) begin
        run_mode_d = live_mode;
        p_d        = live_p;
        h_d        = live_h;
        n_d        = cfg_count;
        cnt_d      = '0;
        phase_d    = '0;
        state_d    = (live_h != '0) ? ST_RUN_HI : ST_RUN_LO;
      end else if (trig) begin
        ovr_d = 1'b1;
      end
    end else begin
      if (trig) begin
        ovr_d = 1'b1;
      end
      if (phase_q == p_q - PW'(1)) begin
        cnt_d = sat_inc(cnt_q);
        if (live_mode == MODE_OFF) begin
          state_d = ST_IDLE;
        end else if ((run_mode_q != MODE_FREE_RUN) && (n_q != '0) &&
                     (({1'b0, cnt_q} + PW'(1)) == {1'b0, n_q})) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          p_d     = live_p;
          h_d     = live_h;
          phase_d = '0;
          state_d = (live_h != '0) ? ST_RUN_HI : ST_RUN_LO;
        end
      end else begin
        phase_d = phase_q + PW'(1);
        state_d = (phase_d < h_q) ? ST_RUN_HI : ST_RUN_LO;
      end
    end

    if (live_mode == MODE_OFF) begin
      ovr_d = 1'b0;
    end

    out_d  = (state_d == ST_RUN_HI) ? LEVEL_HI : LEVEL_LO;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      run_mode_q <= MODE_OFF;
      phase_q    <= '0;
      p_q        <= '0;
      h_q        <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
      out_q      <= LEVEL_LO;
      sw_trig_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_mode_q <= run_mode_d;
      phase_q    <= phase_d;
      p_q        <= p_d;
      h_q        <= h_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
      out_q      <= out_d;
      sw_trig_q  <= sw_trig;
    end
  end

  assign outputa      = out_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pulses_done  = cnt_q;
  assign trig_overrun = ovr_q;

endmodule

// File: doc/pulse_train_scheduler.md
# pulse_train_scheduler

Sequences the instrument's square-wave output stage: programmable period, high time and pulse count, started free-running, by the external trigger, or by a software strobe. Sits between the control-register bank and `outputa`, replacing the hard-coded counter with a configurable, status-reporting scheduler. Configuration is shadowed so that register writes never produce a truncated or glitched pulse.

## Interface
- `LEVEL_HI`, 16'sh7FFF: output level during the high phase.
- `LEVEL_LO`, 16'sh0000: output level during the low phase and when idle.
- `CFG_W`, 14: control-word width.

- `clk` in 1: instrument clock.
- `reset` in 1: synchronous, active-high.
- `exttrig` in 1: external trigger, asynchronous to `clk`.
- `sw_trig` in 1: single-cycle software trigger, synchronous.
- `cfg_mode` in 2: 0 OFF, 1 FREE_RUN, 2 EXT_BURST, 3 SW_BURST.
- `cfg_period` in CFG_W: period is `cfg_period+1` cycles; values below 1 are treated as 1 (minimum period 2).
- `cfg_high` in CFG_W: high cycles per period; clamped to the period.
- `cfg_count` in CFG_W: pulses per burst; 0 means unbounded in the burst modes.
- `outputa` out 16 signed: scheduled level, registered.
- `busy` out 1: high in RUN_HI and RUN_LO.
- `done` out 1: one-cycle strobe when a burst completes.
- `pulses_done` out CFG_W: pulses completed in the current or last burst, saturating.
- `trig_overrun` out 1: sticky; set when a trigger arrives while busy. Cleared by reset or by `cfg_mode`=OFF.

## Operation
- FSM states: IDLE, RUN_HI, RUN_LO.
- IDLE: `outputa`=LEVEL_LO and `busy`=0.
- Start conditions:
  - FREE_RUN: start immediately.
  - EXT_BURST: start on a rising edge of synchronized `exttrig`.
  - SW_BURST: start on `sw_trig`.
- On start, latch shadow values:
  - P = max(cfg_period,1)+1
  - H = min(cfg_high, P)
  - N = cfg_count
- Clear `pulses_done` on start. Set phase counter to 0.
- Within each period, phase counter runs 0..P-1.
  - RUN_HI while phase < H.
  - RUN_LO for the remaining cycles.
  - H=0: stay in RUN_LO for the whole period (output constant low).
  - H=P: stay in RUN_HI for the whole period (output constant high).
- At phase = P-1 (period boundary):
  - Increment `pulses_done`, saturating at 2^CFG_W-1.
  - If N≠0 and `pulses_done`+1 = N: go to IDLE and pulse `done`.
  - Otherwise re-latch P, H from the live config and restart at phase 0.
  - N is never re-latched mid-burst.
- FREE_RUN ignores N and never asserts `done`.
- `cfg_mode` changed to OFF while running: abort at the next period boundary (no truncated pulse), go to IDLE, no `done`.
- Any other mode change takes effect only from IDLE.
- Trigger while busy: ignored and sets `trig_overrun`. A trigger in the same cycle as `done` is also an overrun.
- Reset mid-burst: next cycle `outputa`=LEVEL_LO; state IDLE; `busy`, `done`, `pulses_done`, `trig_overrun` all 0.

## Timing
- Reset values: `outputa`=LEVEL_LO, `busy`=0, `done`=0, `pulses_done`=0, `trig_overrun`=0, state IDLE.
- `outputa` and `busy` are registered from the next state, so they reflect the state entered at that edge.
- `sw_trig` sampled high at edge t: first LEVEL_HI at edge t+1 (when H>0).
- `exttrig` first sampled high at edge t: two-flop synchronizer plus edge register, first LEVEL_HI at edge t+3.
- `exttrig` must be low for at least 2 cycles to re-arm edge detection.
- Each pulse spans exactly H high cycles followed by P-H low cycles, with no idle gap between periods.
- `done` asserts in the same cycle that `outputa` returns to LEVEL_LO after the final period.
- A new trigger is accepted from the cycle after `done`, so back-to-back bursts have a 1-cycle IDLE gap.

## Structure
- Package `pulse_sched_pkg`:
  - mode enum (OFF, FREE_RUN, EXT_BURST, SW_BURST)
  - state enum (IDLE, RUN_HI, RUN_LO)
  - default LEVEL_HI and LEVEL_LO constants
- Sub-module `trig_sync`: 2-flop synchronizer plus rising-edge detector, producing a one-cycle `trig_pulse`. Reset clears all of its flops.
- The top level holds the FSM, the phase counter, the shadow registers and the status logic.

## Test plan
- FREE_RUN, cfg_period=4189, cfg_high=2095 → 2095 cycles at 7FFF, then 2095 at 0000, repeating indefinitely; `done` never asserts.
- SW_BURST, cfg_period=9, cfg_high=3, cfg_count=4, `sw_trig` at edge t:
  - Four pulses, each 3 high and 7 low, first high at t+1.
  - `done` asserts at t+41; `pulses_done`=4; `busy` falls at t+41.
- EXT_BURST, `exttrig` rising mid-cycle, cfg_count=2 → first high exactly 3 edges after the first sampled-high edge. A second `exttrig` during the burst sets `trig_overrun` and does not extend the burst.
- Edge values of cfg_high:
  - cfg_high=0 with cfg_count=3 → output constant 0000; `done` after 3 periods.
  - cfg_high=50 with cfg_period=9 → output constant 7FFF for 30 cycles.
- Register writes mid-burst:
  - Write cfg_period mid-period → current period completes with the old P; new P takes effect from the next boundary.
  - Set cfg_mode=OFF mid-high → pulse finishes its period, then IDLE with no `done`.
- Assert `reset` during RUN_HI → next cycle `outputa`=0000 and all status at 0. A `sw_trig` one cycle after reset is released starts a clean burst.
